// File: rtl/pengtimer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pengtimer_pkg
//  Description : Shared types and constants for the PengTimer sequencing
//                controller (mode encoding, last-digit compare values).
//  Revision    : 1.0 - initial release
// ============================================================================
package pengtimer_pkg;

  // Operating mode; the encoding is visible on the mode output port
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_e;

  // Digit values at which the seconds / minutes counters roll over
  localparam logic [3:0] SEC_LAST_TENS = 4'd5;
  localparam logic [3:0] SEC_LAST_ONES = 4'd9;
  localparam logic [3:0] MIN_LAST_TENS = 4'd5;
  localparam logic [3:0] MIN_LAST_ONES = 4'd9;

endpackage : pengtimer_pkg
`default_nettype wire

// File: rtl/pengtimer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : pengtimer_prescaler
//  Description : Divides clk down to a single-cycle tick every DIV cycles and
//                reports whether the count sits in its lower half (used for
//                the blink phase). A reload restarts the count at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pengtimer_prescaler #(
  parameter int DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic tick,
  output logic low_half
);

  localparam int                  c_PCNT_W = $clog2(DIV);
  localparam logic [c_PCNT_W-1:0] c_LAST   = c_PCNT_W'(DIV - 1);
  localparam logic [c_PCNT_W-1:0] c_HALF   = c_PCNT_W'(DIV / 2);

  logic [c_PCNT_W-1:0] r_pcnt;
  logic [c_PCNT_W-1:0] w_pcnt_nxt;
  logic                r_low_half;

  // Next count: wrap at DIV-1, or restart when reloaded
  always_comb begin
    w_pcnt_nxt = r_pcnt + 1'b1;
    if (reload || (r_pcnt == c_LAST)) begin
      w_pcnt_nxt = '0;
    end
  end

  // Count register plus a registered copy of the lower-half flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt     <= '0;
      r_low_half <= 1'b1;
    end else begin
      r_pcnt     <= w_pcnt_nxt;
      r_low_half <= (w_pcnt_nxt < c_HALF);
    end
  end

  assign tick     = (r_pcnt == c_LAST);
  assign low_half = r_low_half;

endmodule : pengtimer_prescaler
`default_nettype wire

// File: rtl/pengtimer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pengtimer_ctrl
//  Description : PengTimer sequencing controller. Generates the 1 Hz tick,
//                cascaded seconds/minutes/hours count enables and the
//                time-setting mode machine driven by button pulses.
//                Optional feature macro: PENGTIMER_AUTOREPEAT_EN (held
//                increment button auto-repeats in the setting modes).
//  Revision    : 1.0 - initial release
// ============================================================================
module pengtimer_ctrl #(
  parameter int DIV     = 100_000_000,
  parameter int REP_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_hold,
  input  logic [3:0] sec_q1,
  input  logic [3:0] sec_q0,
  input  logic [3:0] min_q1,
  input  logic [3:0] min_q0,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  import pengtimer_pkg::*;

  mode_e r_state;
  mode_e w_state_nxt;

  logic  w_tick;
  logic  w_low_half;
  logic  w_reload;
  logic  w_sec_last;
  logic  w_min_last;
  logic  w_rep_fire;

  logic  w_sec_en_nxt;
  logic  w_min_en_nxt;
  logic  w_hour_en_nxt;
  logic  w_sec_clr_nxt;

  logic  r_sec_en;
  logic  r_min_en;
  logic  r_hour_en;
  logic  r_sec_clr;

  // Restart the 1 Hz phase on return to RUN so the first second is full length
  assign w_reload = w_sec_clr_nxt;

  pengtimer_prescaler #(
    .DIV      (DIV)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .reload   (w_reload),
    .tick     (w_tick),
    .low_half (w_low_half)
  );

  assign w_sec_last = (sec_q1 == SEC_LAST_TENS) && (sec_q0 == SEC_LAST_ONES);
  assign w_min_last = (min_q1 == MIN_LAST_TENS) && (min_q0 == MIN_LAST_ONES);

`ifdef PENGTIMER_AUTOREPEAT_EN
  localparam int c_REP_MAX = (DIV > REP_DIV) ? DIV : REP_DIV;
  localparam int c_REP_W   = (c_REP_MAX > 1) ? $clog2(c_REP_MAX) : 1;

  logic [c_REP_W-1:0] r_rep_cnt;
  logic               r_rep_armed;
  logic               r_rep_phase;
  logic               w_set_mode;
  logic               w_rep_due;

  assign w_set_mode = (r_state == SET_HOUR) || (r_state == SET_MIN);
  // Phase 0 waits out the initial hold delay, phase 1 paces the repeats
  assign w_rep_due  = r_rep_phase ? (r_rep_cnt == c_REP_W'(REP_DIV - 1))
                                  : (r_rep_cnt == c_REP_W'(DIV - 1));
  // A fresh press or a mode change takes precedence over a repeat
  assign w_rep_fire = r_rep_armed && btn_hold && !btn_mode && !btn_inc && w_rep_due;

  // Auto-repeat tracker: armed by a press, dropped on release or mode change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
      r_rep_phase <= 1'b0;
    end else if (btn_mode || !w_set_mode) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
      r_rep_phase <= 1'b0;
    end else if (btn_inc) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b1;
      r_rep_phase <= 1'b0;
    end else if (r_rep_armed && btn_hold) begin
      if (w_rep_due) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b1;
      end else begin
        r_rep_cnt   <= r_rep_cnt + 1'b1;
      end
    end else begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
      r_rep_phase <= 1'b0;
    end
  end
`else
  logic w_unused_hold;

  // The hold level only matters to the auto-repeat feature
  assign w_unused_hold = btn_hold;
  assign w_rep_fire    = 1'b0;
`endif

  // Mode transitions and next-cycle enable/clear pulses
  always_comb begin
    w_state_nxt   = r_state;
    w_sec_en_nxt  = 1'b0;
    w_min_en_nxt  = 1'b0;
    w_hour_en_nxt = 1'b0;
    w_sec_clr_nxt = 1'b0;
    case (r_state)
      RUN: begin
        if (btn_mode) begin
          // A coincident tick is dropped together with the mode change
          w_state_nxt = SET_HOUR;
        end else begin
          w_sec_en_nxt  = w_tick;
          w_min_en_nxt  = w_tick && w_sec_last;
          w_hour_en_nxt = w_tick && w_sec_last && w_min_last;
        end
      end
      SET_HOUR: begin
        if (btn_mode) begin
          w_state_nxt = SET_MIN;
        end else begin
          w_hour_en_nxt = btn_inc || w_rep_fire;
        end
      end
      SET_MIN: begin
        if (btn_mode) begin
          w_state_nxt   = RUN;
          w_sec_clr_nxt = 1'b1;
        end else begin
          // Minute wrap in this mode never carries into the hours
          w_min_en_nxt = btn_inc || w_rep_fire;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_sec_en  <= 1'b0;
      r_min_en  <= 1'b0;
      r_hour_en <= 1'b0;
      r_sec_clr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sec_en  <= w_sec_en_nxt;
      r_min_en  <= w_min_en_nxt;
      r_hour_en <= w_hour_en_nxt;
      r_sec_clr <= w_sec_clr_nxt;
    end
  end

  assign sec_en  = r_sec_en;
  assign min_en  = r_min_en;
  assign hour_en = r_hour_en;
  assign sec_clr = r_sec_clr;
  assign mode    = r_state;
  // Both terms come straight from flops, so blink tracks mode and count phase
  assign blink   = ((r_state == SET_HOUR) || (r_state == SET_MIN)) && w_low_half;

endmodule : pengtimer_ctrl
`default_nettype wire

// File: tb/tb_pengtimer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pengtimer_ctrl
//  Description : Self-checking bench for pengtimer_ctrl at DIV=4, REP_DIV=2.
//                Directed scenarios plus randomized button/digit stimulus
//                checked against a cycle-count reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pengtimer_ctrl;

  localparam int DIV     = 4;
  localparam int REP_DIV = 2;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_hold;
  logic [3:0] sec_q1;
  logic [3:0] sec_q0;
  logic [3:0] min_q1;
  logic [3:0] min_q0;
  logic       sec_en;
  logic       min_en;
  logic       hour_en;
  logic       sec_clr;
  logic [1:0] mode;
  logic       blink;

  // {sec_en, min_en, hour_en, sec_clr, mode[1:0], blink}
  logic [6:0] obs;
  assign obs = {sec_en, min_en, hour_en, sec_clr, mode, blink};

  int n_total = 0;
  int n_bad   = 0;

  pengtimer_ctrl #(
    .DIV      (DIV),
    .REP_DIV  (REP_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .btn_hold (btn_hold),
    .sec_q1   (sec_q1),
    .sec_q0   (sec_q0),
    .min_q1   (min_q1),
    .min_q0   (min_q0),
    .sec_en   (sec_en),
    .min_en   (min_en),
    .hour_en  (hour_en),
    .sec_clr  (sec_clr),
    .mode     (mode),
    .blink    (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input int s, input int m);
    sec_q1 = 4'(s / 10);
    sec_q0 = 4'(s % 10);
    min_q1 = 4'(m / 10);
    min_q0 = 4'(m % 10);
  endtask

  // Leaves the bench one edge after reset: prescaler phase 0, mode RUN
  task automatic do_reset();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_hold = 1'b0;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_mode = 1'b1; btn_inc = 1'b1; btn_hold = 1'b0;
    set_digits(59, 59);
    step();
    n_total++;
    if (obs !== 7'b0) begin
      n_bad++; $display("FAIL reset_state got=%b exp=%b", obs, 7'b0);
    end
    step();
    n_total++;
    if (obs !== 7'b0) begin
      n_bad++; $display("FAIL reset_hold got=%b exp=%b", obs, 7'b0);
    end
    rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    step();
    n_total++;
    if (obs !== 7'b0) begin
      n_bad++; $display("FAIL reset_release got=%b exp=%b", obs, 7'b0);
    end
  endtask

  task automatic test_run_count();
    logic [6:0] e;
    set_digits(0, 0);
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step();
      e = {(k % DIV == 0), 6'b0};
      n_total++;
      if (obs !== e) begin
        n_bad++; $display("FAIL run_count cyc=%0d got=%b exp=%b", k, obs, e);
      end
    end
  endtask

  task automatic test_rollover();
    logic [15:0] dig [5];
    logic [2:0]  ens [5];
    logic [6:0]  e;
    dig[0] = 16'h5959; ens[0] = 3'b111;
    dig[1] = 16'h5958; ens[1] = 3'b110;
    dig[2] = 16'h5859; ens[2] = 3'b100;
    dig[3] = 16'hF959; ens[3] = 3'b100;
    dig[4] = 16'h59F9; ens[4] = 3'b110;
    for (int p = 0; p < 5; p++) begin
      {sec_q1, sec_q0, min_q1, min_q0} = dig[p];
      do_reset();
      step(); step(); step();
      n_total++;
      if (obs !== 7'b0) begin
        n_bad++; $display("FAIL rollover_pre pat=%0d got=%b exp=%b", p, obs, 7'b0);
      end
      step();
      e = {ens[p], 4'b0};
      n_total++;
      if (obs !== e) begin
        n_bad++; $display("FAIL rollover pat=%0d got=%b exp=%b", p, obs, e);
      end
    end
  endtask

  task automatic test_set_hour();
    logic [6:0] e;
    int         n_hour = 0;
    set_digits(0, 0);
    do_reset();
    for (int k = 0; k < 12; k++) begin
      btn_mode = (k == 0);
      btn_inc  = (k == 2) || (k == 4) || (k == 6);
      step();
      btn_mode = 1'b0; btn_inc = 1'b0;
      if (hour_en === 1'b1) n_hour++;
      e = {2'b00, ((k + 1) == 3 || (k + 1) == 5 || (k + 1) == 7), 1'b0,
           2'd1, (((k + 1) % DIV) < DIV / 2)};
      n_total++;
      if (obs !== e) begin
        n_bad++; $display("FAIL set_hour cyc=%0d got=%b exp=%b", k + 1, obs, e);
      end
    end
    n_total++;
    if (n_hour != 3) begin
      n_bad++; $display("FAIL set_hour_count got=%0d exp=3", n_hour);
    end
  endtask

  task automatic test_set_min_exit();
    logic [6:0] e [1:9];
    e[1] = 7'b0000011; e[2] = 7'b0000100; e[3] = 7'b0100100;
    e[4] = 7'b0001000; e[5] = 7'b0000000; e[6] = 7'b0000000;
    e[7] = 7'b0000000; e[8] = 7'b1000000; e[9] = 7'b0000000;
    set_digits(0, 59);
    do_reset();
    for (int k = 0; k < 9; k++) begin
      btn_mode = (k == 0) || (k == 1) || (k == 3);
      btn_inc  = (k == 2);
      step();
      btn_mode = 1'b0; btn_inc = 1'b0;
      n_total++;
      if (obs !== e[k + 1]) begin
        n_bad++; $display("FAIL set_min_exit cyc=%0d got=%b exp=%b", k + 1, obs, e[k + 1]);
      end
    end
  endtask

  task automatic test_simultaneous();
    set_digits(0, 0);
    do_reset();
    btn_mode = 1'b1; step();
    btn_inc  = 1'b1; step();
    btn_mode = 1'b0; btn_inc = 1'b0;
    n_total++;
    if (obs !== 7'b0000100) begin
      n_bad++; $display("FAIL mode_over_inc got=%b exp=%b", obs, 7'b0000100);
    end
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    set_digits(59, 59);
    step(); step(); step();
    n_total++;
    if (obs !== 7'b0) begin
      n_bad++; $display("FAIL pre_tick_run got=%b exp=%b", obs, 7'b0);
    end
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    n_total++;
    if (obs !== 7'b0000011) begin
      n_bad++; $display("FAIL mode_over_tick got=%b exp=%b", obs, 7'b0000011);
    end
    step();
    n_total++;
    if (obs !== 7'b0000011) begin
      n_bad++; $display("FAIL mode_over_tick_after got=%b exp=%b", obs, 7'b0000011);
    end
  endtask

  task automatic test_reset_mid();
    set_digits(0, 59);
    do_reset();
    btn_mode = 1'b1; step(); step(); btn_mode = 1'b0;
    rst = 1'b1; btn_inc = 1'b1; step();
    rst = 1'b0; btn_inc = 1'b0;
    n_total++;
    if (obs !== 7'b0) begin
      n_bad++; $display("FAIL reset_mid got=%b exp=%b", obs, 7'b0);
    end
    step();
    n_total++;
    if (obs !== 7'b0) begin
      n_bad++; $display("FAIL reset_mid_next got=%b exp=%b", obs, 7'b0);
    end
    step(); step(); step();
    n_total++;
    if (obs !== 7'b1000000) begin
      n_bad++; $display("FAIL reset_mid_tick got=%b exp=%b", obs, 7'b1000000);
    end
  endtask

  task automatic test_hold();
    logic [2:0] e;
    logic       extra;
    int         j;
    set_digits(0, 0);
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      btn_mode = (k == 0);
      btn_inc  = (k == 1);
      btn_hold = (k >= 1) && (k <= 12);
      j = k - 1;
`ifdef PENGTIMER_AUTOREPEAT_EN
      extra = (j >= DIV) && (((j - DIV) % REP_DIV) == 0) && btn_hold;
`else
      extra = 1'b0;
`endif
      step();
      btn_mode = 1'b0; btn_inc = 1'b0;
      e = {2'b00, (k == 1) || extra};
      n_total++;
      if ({sec_en, min_en, hour_en} !== e) begin
        n_bad++; $display("FAIL hold_repeat cyc=%0d got=%b exp=%b", k + 1,
                          {sec_en, min_en, hour_en}, e);
      end
    end
    btn_hold = 1'b0;
  endtask

  // Reference: mode sequence plus elapsed cycles since the last 1 Hz restart
  task automatic test_random();
    int         m_mode;
    int         m_el;
    bit         bm, bi, tk, s59, m59;
    bit         x_sec, x_min, x_hour, x_clr, x_blink;
    logic [6:0] e;
    do_reset();
    m_mode = 0;
    m_el   = 0;
    for (int k = 0; k < 300; k++) begin
      bm = ($urandom_range(0, 7) == 0);
      bi = ($urandom_range(0, 2) == 0);
      sec_q1 = ($urandom_range(0, 1) == 1) ? 4'd5 : 4'($urandom_range(0, 15));
      sec_q0 = ($urandom_range(0, 1) == 1) ? 4'd9 : 4'($urandom_range(0, 15));
      min_q1 = ($urandom_range(0, 1) == 1) ? 4'd5 : 4'($urandom_range(0, 15));
      min_q0 = ($urandom_range(0, 1) == 1) ? 4'd9 : 4'($urandom_range(0, 15));
      btn_mode = bm;
      btn_inc  = bi;
      tk  = (m_el % DIV) == (DIV - 1);
      s59 = (sec_q1 == 4'd5) && (sec_q0 == 4'd9);
      m59 = (min_q1 == 4'd5) && (min_q0 == 4'd9);
      x_sec  = !bm && (m_mode == 0) && tk;
      x_min  = !bm && (((m_mode == 0) && tk && s59) || ((m_mode == 2) && bi));
      x_hour = !bm && (((m_mode == 0) && tk && s59 && m59) || ((m_mode == 1) && bi));
      x_clr  = bm && (m_mode == 2);
      if (bm) m_mode = (m_mode + 1) % 3;
      m_el    = x_clr ? 0 : m_el + 1;
      x_blink = (m_mode != 0) && ((m_el % DIV) < DIV / 2);
      step();
      e = {x_sec, x_min, x_hour, x_clr, 2'(m_mode), x_blink};
      n_total++;
      if (obs !== e) begin
        n_bad++; $display("FAIL random cyc=%0d got=%b exp=%b", k, obs, e);
      end
    end
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_hold = 1'b0;
    set_digits(0, 0);
    test_reset();
    test_run_count();
    test_rollover();
    test_set_hour();
    test_set_min_exit();
    test_simultaneous();
    test_reset_mid();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_pengtimer_ctrl
`default_nettype wire

// File: doc/pengtimer_ctrl.md
# pengtimer_ctrl

Sequencing controller for the PengTimer clock datapath. It divides `clk` down to a 1 Hz tick and issues cascaded single-cycle count enables to the seconds, minutes and hours BCD counters. It runs a user time-setting state machine driven by pre-debounced button pulses. It sits between the button front-end and the counter chain; the counters only count when enabled and wrap on their own.

## Interface
- `DIV`, default 100_000_000: clk cycles per tick; legal range DIV ≥ 4, DIV even.
- `REP_DIV`, default 12_500_000: auto-repeat increment period in clk cycles; used only with the auto-repeat feature (see Configuration).
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `btn_mode` in 1: one-cycle pulse; advances the setting mode.
- `btn_inc` in 1: one-cycle pulse; increments the selected field.
- `btn_hold` in 1: level, increment button held; used only with the auto-repeat feature.
- `sec_q1`, `sec_q0` in 4 each: seconds tens/ones from the seconds counter.
- `min_q1`, `min_q0` in 4 each: minutes tens/ones from the minutes counter.
- `sec_en` out 1: seconds count enable pulse.
- `min_en` out 1: minutes count enable pulse.
- `hour_en` out 1: hours count enable pulse.
- `sec_clr` out 1: one-cycle synchronous clear for the seconds counter.
- `mode` out 2: current mode, encoded RUN=0, SET_HOUR=1, SET_MIN=2.
- `blink` out 1: display blank phase for the field being set.

## Operation
- Prescaler `pcnt` counts 0..DIV-1 and wraps. Internal `tick` is true when `pcnt == DIV-1`.
- FSM states and transitions:
  - RUN → SET_HOUR on `btn_mode`.
  - SET_HOUR → SET_MIN on `btn_mode`.
  - SET_MIN → RUN on `btn_mode`.
  - Encoding 3 is unreachable; if entered, the next state is RUN.
- RUN:
  - `sec_en` on `tick`.
  - `min_en` on `tick` with seconds == 59 (q1=5, q0=9).
  - `hour_en` on `tick` with seconds == 59 and minutes == 59.
  - `btn_inc` is ignored.
- SET_HOUR: no tick-driven enables. `btn_inc` → `hour_en` only.
- SET_MIN: no tick-driven enables. `btn_inc` → `min_en` only. Minutes wrapping 59→00 never produces `hour_en`.
- Leaving SET_MIN for RUN:
  - `sec_clr` is pulsed.
  - `pcnt` is reloaded to 0, so the first RUN tick occurs DIV cycles later.
- `blink` = 1 when in SET_HOUR or SET_MIN and `pcnt < DIV/2`; otherwise 0. It is always 0 in RUN.
- Simultaneous events:
  - `btn_mode` has priority over `btn_inc`; the `btn_inc` in that cycle is dropped.
  - `btn_mode` in the same cycle as `tick` in RUN: the tick's enables are suppressed and the mode changes.
- Counter values are compared as raw 4-bit digits; no range check is performed.

## Timing
- All outputs are registered. Each enable is high for exactly one cycle, the cycle after the triggering `tick` or `btn_inc`.
- `mode` updates the cycle after `btn_mode`.
- `sec_clr` is asserted in the same cycle that `mode` first reads RUN.
- DIV ≥ 4 guarantees the counters have updated `sec_q*`/`min_q*` before the next tick compare.
- Reset, including mid-operation, applies on the next rising edge:
  - `mode` = RUN, `pcnt` = 0, repeat counter = 0.
  - `sec_en`, `min_en`, `hour_en`, `sec_clr` and `blink` all = 0.
  - Any pending button event is discarded.

## Configuration
- Macro `PENGTIMER_AUTOREPEAT_EN`.
- Defined:
  - In SET_HOUR or SET_MIN, when `btn_hold` stays high for DIV cycles after a `btn_inc`, the block issues one extra increment of the selected field every REP_DIV cycles.
  - Repeating continues until `btn_hold` falls or the mode changes.
  - The repeat counter resets on every `btn_inc`.
- Undefined: `btn_hold` remains a port but is ignored, and no repeat logic is synthesized.

## Structure
- Shared package `pengtimer_pkg` holds:
  - the mode enum (RUN, SET_HOUR, SET_MIN);
  - constants SEC_LAST_TENS=5, SEC_LAST_ONES=9, MIN_LAST_TENS=5, MIN_LAST_ONES=9.
- One sub-module, `pengtimer_prescaler`:
  - parameter DIV;
  - inputs `clk`, `rst`, `reload`;
  - outputs `tick` and `low_half` (`pcnt < DIV/2`).
- The FSM and enable logic stay in `pengtimer_ctrl`.

## Test plan
- Run at DIV=4 from reset with seconds held at 00 → `sec_en` pulses every 4 cycles; `min_en` and `hour_en` stay 0; `mode`=0; `blink`=0.
- Drive seconds=59, minutes=59 at tick → `sec_en`, `min_en` and `hour_en` all pulse in the same cycle, one cycle after the tick.
- `btn_mode`, then 3× `btn_inc` → `mode`=1; exactly 3 `hour_en` pulses and 0 `sec_en`; `blink` toggles with period 4.
- Enter SET_MIN with minutes=59, pulse `btn_inc`, then `btn_mode` → one `min_en` with no `hour_en`; `mode` returns to 0 with `sec_clr`=1 in the same cycle; first `sec_en` occurs 4 cycles later.
- `btn_mode` and `btn_inc` in the same cycle in SET_HOUR → `mode`=2 and no `hour_en`; assert `rst` mid-SET_MIN → next cycle `mode`=0 and all outputs 0.
- With `PENGTIMER_AUTOREPEAT_EN` defined, DIV=4, REP_DIV=2, in SET_HOUR: `btn_inc` with `btn_hold` high for 12 cycles → 1 initial `hour_en`, then one every 2 cycles after cycle 4; no further pulses after `btn_hold` falls.
